// File: rtl/tl_mon_pkg.sv
// Shared opcodes, error codes and helper functions for the TileLink link monitor.
package tl_mon_pkg;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITHMETIC  = 3'd2;
  localparam logic [2:0] A_LOGICAL     = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_INTENT      = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  typedef enum logic [3:0] {
    ERR_NONE     = 4'd0,
    ERR_A_OPCODE = 4'd1,
    ERR_A_ALIGN  = 4'd2,
    ERR_A_BUSY   = 4'd3,
    ERR_A_BURST  = 4'd4,
    ERR_A_STABLE = 4'd5,
    ERR_D_NOREQ  = 4'd6,
    ERR_D_OPCODE = 4'd7,
    ERR_D_SIZE   = 4'd8,
    ERR_D_BURST  = 4'd9,
    ERR_D_STABLE = 4'd10,
    ERR_TIMEOUT  = 4'd11
  } err_code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

  // Number of bus beats needed to move 2^size bytes.
  function automatic int unsigned tl_beats(input int unsigned size, input int unsigned beat_bytes);
    int unsigned bytes;
    bytes = 32'd1 << size;
    if (bytes <= beat_bytes) return 32'd1;
    return bytes / beat_bytes;
  endfunction

  // D opcode a correct slave answers with for a given A opcode.
  function automatic logic [2:0] tl_exp_d_opcode(input logic [2:0] a_opcode);
    logic [2:0] d_op;
    case (a_opcode)
      A_PUT_FULL, A_PUT_PARTIAL:       d_op = D_ACCESS_ACK;
      A_GET, A_ARITHMETIC, A_LOGICAL:  d_op = D_ACCESS_ACK_DATA;
      A_INTENT:                        d_op = D_HINT_ACK;
      default:                         d_op = D_ACCESS_ACK;
    endcase
    return d_op;
  endfunction

  // A requests that carry write data use one beat per BEAT_BYTES.
  function automatic logic tl_a_has_data(input logic [2:0] a_opcode);
    return (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL) ||
           (a_opcode == A_ARITHMETIC) || (a_opcode == A_LOGICAL);
  endfunction

  function automatic logic tl_a_legal(input logic [2:0] a_opcode, input logic uh_en);
    logic ok;
    case (a_opcode)
      A_PUT_FULL, A_PUT_PARTIAL, A_GET:   ok = 1'b1;
      A_ARITHMETIC, A_LOGICAL, A_INTENT:  ok = uh_en;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tl_mon_burst_tracker.sv
// Per-channel burst tracker: beat down-counter, first/last flags, field
// capture on the first beat and valid/field hold check while stalled.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | next fire is a first beat
//   ST_BURST | inside a multi-beat burst, cnt_q beats still to come
module tl_mon_burst_tracker
  import tl_mon_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int CAP_W  = 8,
  parameter int STAB_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid,
  input  logic              ready,
  input  logic [CNT_W-1:0]  beats,
  input  logic [CAP_W-1:0]  cap_fields,
  input  logic [STAB_W-1:0] stab_fields,
  output logic              first,
  output logic              last,
  output logic              burst_err,
  output logic              stable_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  burst_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CAP_W-1:0]  cap_q;
  logic [STAB_W-1:0] stab_q;
  logic              stall_q;
  logic              fire;

  assign fire = valid & ready;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus first/last/burst flags for the current beat.
  always_comb begin
    state_d   = state_q;
    first     = 1'b0;
    last      = 1'b0;
    burst_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          first = 1'b1;
          if (beats > CNT_ONE) state_d = ST_BURST;
          else                 last    = 1'b1;
        end
      end
      ST_BURST: begin
        if (fire) begin
          burst_err = (cap_fields != cap_q);
          if (cnt_q == CNT_ONE) begin
            last    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Remaining-beat counter and first-beat field capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      cap_q <= '0;
    end else if (fire) begin
      if (state_q == ST_IDLE) begin
        cnt_q <= beats - CNT_ONE;
        cap_q <= cap_fields;
      end else begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  // Remember last cycle's stall and fields for the hold check.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
      stab_q  <= '0;
    end else begin
      stall_q <= valid & ~ready;
      stab_q  <= stab_fields;
    end
  end

  assign stable_err = stall_q & (~valid | (stab_fields != stab_q));

endmodule

// File: rtl/tl_ul_protocol_monitor.sv
// Passive checker for one TileLink-UL/UH A/D link: per-source in-flight
// table, burst and stability checks, response timeouts, error reporting.
module tl_ul_protocol_monitor
  import tl_mon_pkg::*;
#(
  parameter int SOURCE_W   = 2,
  parameter int ADDR_W     = 32,
  parameter int SIZE_W     = 3,
  parameter int BEAT_BYTES = 4,
  parameter int UH_EN      = 0,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  a_valid,
  input  logic                  a_ready,
  input  logic [2:0]            a_opcode,
  input  logic [2:0]            a_param,
  input  logic [SIZE_W-1:0]     a_size,
  input  logic [SOURCE_W-1:0]   a_source,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [BEAT_BYTES-1:0] a_mask,
  input  logic                  d_valid,
  input  logic                  d_ready,
  input  logic [2:0]            d_opcode,
  input  logic [1:0]            d_param,
  input  logic [SIZE_W-1:0]     d_size,
  input  logic [SOURCE_W-1:0]   d_source,
  input  logic                  d_denied,
  input  logic                  d_corrupt,
  output logic                  err_valid,
  output logic [3:0]            err_code,
  output logic                  err_sticky,
  output logic [SOURCE_W-1:0]   err_source,
  output logic [7:0]            err_count,
  output logic [SOURCE_W:0]     inflight
);

  localparam int NSRC     = 1 << SOURCE_W;
  localparam int CNT_W    = 1 << SIZE_W;
  localparam int LANE_W   = $clog2(BEAT_BYTES);
  localparam int TMR_W    = $clog2(TIMEOUT + 2);
  localparam int A_CAP_W  = 6 + SIZE_W + SOURCE_W + ADDR_W;
  localparam int A_STAB_W = A_CAP_W + BEAT_BYTES;
  localparam int D_CAP_W  = 5 + SIZE_W + SOURCE_W;
  localparam int D_STAB_W = D_CAP_W + 2;

  // Any address bit below the transfer size set means misaligned.
  function automatic logic misaligned(input logic [ADDR_W-1:0] addr, input logic [SIZE_W-1:0] size);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < ADDR_W; i++) begin
      if ((i < int'(size)) && addr[i]) bad = 1'b1;
    end
    return bad;
  endfunction

  // Byte lanes a Get of 2^size bytes at addr must enable.
  function automatic logic [BEAT_BYTES-1:0] lane_mask(input logic [ADDR_W-1:0] addr, input logic [SIZE_W-1:0] size);
    logic [BEAT_BYTES-1:0] m;
    int bytes;
    int off;
    bytes = 1 << size;
    off   = 0;
    for (int b = 0; b < LANE_W; b++) begin
      if (addr[b]) off = off + (1 << b);
    end
    for (int i = 0; i < BEAT_BYTES; i++) begin
      m[i] = (bytes >= BEAT_BYTES) || ((i >= off) && (i < off + bytes));
    end
    return m;
  endfunction

  logic                a_fire;
  logic [CNT_W-1:0]    a_beats, d_beats;
  logic                a_first, a_last, a_burst_err, a_stable_err;
  logic                d_first, d_last, d_burst_err, d_stable_err;
  logic                unused_a_last;

  logic [NSRC-1:0]     busy_q, busy_d, set_vec, clr_vec;
  logic [2:0]          op_q   [NSRC];
  logic [SIZE_W-1:0]   size_q [NSRC];
  logic [NSRC-1:0]     to_pend, to_grant;
  logic [SOURCE_W:0]   infl_d;

  logic                err_hit;
  err_code_e           err_code_d;
  logic [SOURCE_W-1:0] err_src_d;
  logic [SOURCE_W-1:0] to_idx;
  logic                a_align_bad;

  assign a_fire  = a_valid & a_ready;
  assign a_beats = tl_a_has_data(a_opcode) ? CNT_W'(tl_beats(32'(a_size), BEAT_BYTES)) : CNT_W'(1);
  assign d_beats = (d_opcode == D_ACCESS_ACK_DATA) ? CNT_W'(tl_beats(32'(d_size), BEAT_BYTES)) : CNT_W'(1);

  // The table only cares when an A request starts, never when it ends.
  assign unused_a_last = a_last;

  tl_mon_burst_tracker #(
    .CNT_W  (CNT_W),
    .CAP_W  (A_CAP_W),
    .STAB_W (A_STAB_W)
  ) u_a_track (
    .clock       (clock),
    .reset_n     (reset_n),
    .valid       (a_valid),
    .ready       (a_ready),
    .beats       (a_beats),
    .cap_fields  ({a_opcode, a_param, a_size, a_source, a_address}),
    .stab_fields ({a_opcode, a_param, a_size, a_source, a_address, a_mask}),
    .first       (a_first),
    .last        (a_last),
    .burst_err   (a_burst_err),
    .stable_err  (a_stable_err)
  );

  tl_mon_burst_tracker #(
    .CNT_W  (CNT_W),
    .CAP_W  (D_CAP_W),
    .STAB_W (D_STAB_W)
  ) u_d_track (
    .clock       (clock),
    .reset_n     (reset_n),
    .valid       (d_valid),
    .ready       (d_ready),
    .beats       (d_beats),
    .cap_fields  ({d_opcode, d_param, d_size, d_source}),
    .stab_fields ({d_opcode, d_param, d_size, d_source, d_denied, d_corrupt}),
    .first       (d_first),
    .last        (d_last),
    .burst_err   (d_burst_err),
    .stable_err  (d_stable_err)
  );

  // Per-source set/clear requests; a set overrides a same-cycle clear.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    infl_d  = '0;
    for (int s = 0; s < NSRC; s++) begin
      set_vec[s] = a_first && (a_source == SOURCE_W'(s));
      clr_vec[s] = d_last && (d_source == SOURCE_W'(s));
    end
    busy_d = (busy_q & ~clr_vec) | set_vec;
    for (int s = 0; s < NSRC; s++) begin
      infl_d = infl_d + (SOURCE_W+1)'(busy_d[s]);
    end
  end

  // Source table: busy flag plus the request opcode and size.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      for (int s = 0; s < NSRC; s++) begin
        op_q[s]   <= '0;
        size_q[s] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int s = 0; s < NSRC; s++) begin
        if (set_vec[s]) begin
          op_q[s]   <= a_opcode;
          size_q[s] <= a_size;
        end
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT + 1);
      logic [TMR_W-1:0] tmr_q [NSRC];
      logic [NSRC-1:0]  to_done_q;

      // Remaining-cycles timer per source; zero means age hit TIMEOUT+1.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          to_done_q <= '0;
          for (int s = 0; s < NSRC; s++) tmr_q[s] <= '0;
        end else begin
          for (int s = 0; s < NSRC; s++) begin
            if (set_vec[s])                          tmr_q[s] <= TMR_LOAD;
            else if (busy_q[s] && (tmr_q[s] != '0))  tmr_q[s] <= tmr_q[s] - 1'b1;
            if (set_vec[s] || clr_vec[s]) to_done_q[s] <= 1'b0;
            else if (to_grant[s])         to_done_q[s] <= 1'b1;
          end
        end
      end

      // A source is reported once, then silenced until it clears.
      always_comb begin
        to_pend = '0;
        for (int s = 0; s < NSRC; s++) begin
          to_pend[s] = busy_q[s] && (tmr_q[s] == '0) && !to_done_q[s];
        end
      end
    end else begin : g_no_timeout
      logic [NSRC-1:0] unused_to_grant;
      assign unused_to_grant = to_grant;
      assign to_pend = '0;
    end
  endgenerate

  assign a_align_bad = misaligned(a_address, a_size) ||
                       ((a_opcode == A_GET) && (a_mask != lane_mask(a_address, a_size)));

  // Priority encode this cycle's violations; the lowest code wins.
  always_comb begin
    err_hit    = 1'b1;
    err_code_d = ERR_NONE;
    err_src_d  = '0;
    to_grant   = '0;
    to_idx     = '0;
    for (int s = NSRC - 1; s >= 0; s--) begin
      if (to_pend[s]) to_idx = SOURCE_W'(s);
    end
    if (a_fire && !tl_a_legal(a_opcode, UH_EN != 0)) begin
      err_code_d = ERR_A_OPCODE;
      err_src_d  = a_source;
    end else if (a_fire && a_align_bad) begin
      err_code_d = ERR_A_ALIGN;
      err_src_d  = a_source;
    end else if (a_first && busy_q[a_source] && !clr_vec[a_source]) begin
      err_code_d = ERR_A_BUSY;
      err_src_d  = a_source;
    end else if (a_burst_err) begin
      err_code_d = ERR_A_BURST;
      err_src_d  = a_source;
    end else if (a_stable_err) begin
      err_code_d = ERR_A_STABLE;
      err_src_d  = a_source;
    end else if (d_first && !busy_q[d_source]) begin
      err_code_d = ERR_D_NOREQ;
      err_src_d  = d_source;
    end else if (d_first && (d_opcode != tl_exp_d_opcode(op_q[d_source]))) begin
      err_code_d = ERR_D_OPCODE;
      err_src_d  = d_source;
    end else if (d_first && (d_size != size_q[d_source])) begin
      err_code_d = ERR_D_SIZE;
      err_src_d  = d_source;
    end else if (d_burst_err) begin
      err_code_d = ERR_D_BURST;
      err_src_d  = d_source;
    end else if (d_stable_err) begin
      err_code_d = ERR_D_STABLE;
      err_src_d  = d_source;
    end else if (|to_pend) begin
      err_code_d       = ERR_TIMEOUT;
      err_src_d        = to_idx;
      to_grant[to_idx] = 1'b1;
    end else begin
      err_hit = 1'b0;
    end
  end

  // Registered error reporting and in-flight count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_sticky <= 1'b0;
      err_source <= '0;
      err_count  <= '0;
      inflight   <= '0;
    end else begin
      err_valid <= err_hit;
      inflight  <= infl_d;
      if (err_hit) begin
        err_code   <= err_code_d;
        err_source <= err_src_d;
        err_sticky <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
